// File: rtl/baccarat_pkg.sv
// Shared types and card rules for the baccarat dealing datapath.
package baccarat_pkg;

  localparam int CARD_W = 4;

  // Deal sequencer states, one step per slow_clock edge.
  typedef enum logic [3:0] {
    DEAL_P1 = 4'd0,
    DEAL_D1 = 4'd1,
    DEAL_P2 = 4'd2,
    DEAL_D2 = 4'd3,
    EVAL    = 4'd4,
    DEAL_P3 = 4'd5,
    BEVAL   = 4'd6,
    DEAL_D3 = 4'd7,
    DONE    = 4'd8
  } state_t;

  // Codes 1-9 count face value; 0 and the picture/unused codes 10-15 count zero.
  function automatic logic [CARD_W-1:0] card_value(input logic [CARD_W-1:0] code);
    return ((code >= CARD_W'(1)) && (code <= CARD_W'(9))) ? code : '0;
  endfunction

  // Banker third-card tableau, given banker score and value of the player's third card.
  function automatic logic banker_draws(input logic [CARD_W-1:0] dscore,
                                        input logic [CARD_W-1:0] p3_val);
    logic draw;
    draw = 1'b0;
    case (dscore)
      CARD_W'(0), CARD_W'(1), CARD_W'(2): draw = 1'b1;
      CARD_W'(3): draw = (p3_val != CARD_W'(8));
      CARD_W'(4): draw = (p3_val >= CARD_W'(2)) && (p3_val <= CARD_W'(7));
      CARD_W'(5): draw = (p3_val >= CARD_W'(4)) && (p3_val <= CARD_W'(7));
      CARD_W'(6): draw = (p3_val >= CARD_W'(6)) && (p3_val <= CARD_W'(7));
      default:    draw = 1'b0;
    endcase
    return draw;
  endfunction

endpackage

// File: rtl/hand_score.sv
// Three-card baccarat hand score: sum of card values modulo 10.
module hand_score
  import baccarat_pkg::*;
(
  input  logic [CARD_W-1:0] i_card1,
  input  logic [CARD_W-1:0] i_card2,
  input  logic [CARD_W-1:0] i_card3,
  output logic [CARD_W-1:0] o_score
);

  logic [4:0] w_sum;
  logic [4:0] w_mod;

  // Sum is at most 27, so two conditional subtractions replace a divider.
  always_comb begin
    w_sum = {1'b0, card_value(i_card1)} + {1'b0, card_value(i_card2)}
          + {1'b0, card_value(i_card3)};
    w_mod = w_sum;
    if (w_sum >= 5'd20)      w_mod = w_sum - 5'd20;
    else if (w_sum >= 5'd10) w_mod = w_sum - 5'd10;
  end

  assign o_score = w_mod[CARD_W-1:0];

endmodule

// File: rtl/baccarat_dealer.sv
// Baccarat dealing engine: loads one card per edge into player/banker
// registers, applies the third-card tableau and drives the win lights.
module baccarat_dealer
  import baccarat_pkg::state_t, baccarat_pkg::DEAL_P1, baccarat_pkg::DEAL_D1,
         baccarat_pkg::DEAL_P2, baccarat_pkg::DEAL_D2, baccarat_pkg::EVAL,
         baccarat_pkg::DEAL_P3, baccarat_pkg::BEVAL, baccarat_pkg::DEAL_D3,
         baccarat_pkg::DONE, baccarat_pkg::card_value, baccarat_pkg::banker_draws;
#(
  parameter int CARD_W = 4
) (
  input  logic              slow_clock,
  input  logic              resetb,
  input  logic [CARD_W-1:0] new_card,
  output logic [CARD_W-1:0] pcard1,
  output logic [CARD_W-1:0] pcard2,
  output logic [CARD_W-1:0] pcard3,
  output logic [CARD_W-1:0] dcard1,
  output logic [CARD_W-1:0] dcard2,
  output logic [CARD_W-1:0] dcard3,
  output logic [CARD_W-1:0] pscore,
  output logic [CARD_W-1:0] dscore,
  output logic              player_win_light,
  output logic              dealer_win_light,
  output logic              done,
  output state_t            dbg_state
);

  state_t r_state;
  state_t w_next;
  logic [CARD_W-1:0] r_pcard1, r_pcard2, r_pcard3;
  logic [CARD_W-1:0] r_dcard1, r_dcard2, r_dcard3;
  logic [CARD_W-1:0] w_pscore, w_dscore;
  logic              w_natural;

  hand_score u_player (
    .i_card1 (r_pcard1),
    .i_card2 (r_pcard2),
    .i_card3 (r_pcard3),
    .o_score (w_pscore)
  );

  hand_score u_banker (
    .i_card1 (r_dcard1),
    .i_card2 (r_dcard2),
    .i_card3 (r_dcard3),
    .o_score (w_dscore)
  );

  assign w_natural = (w_pscore >= CARD_W'(8)) || (w_dscore >= CARD_W'(8));

  // State register; reset aborts any hand in progress.
  always_ff @(posedge slow_clock) begin
    if (!resetb) r_state <= DEAL_P1;
    else         r_state <= w_next;
  end

  // Next-state: fixed four-card deal, then natural/draw decisions.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DEAL_P1: w_next = DEAL_D1;
      DEAL_D1: w_next = DEAL_P2;
      DEAL_P2: w_next = DEAL_D2;
      DEAL_D2: w_next = EVAL;
      EVAL: begin
        if (w_natural)                       w_next = DONE;
        else if (w_pscore <= CARD_W'(5))     w_next = DEAL_P3;
        else if (w_dscore <= CARD_W'(5))     w_next = DEAL_D3;
        else                                 w_next = DONE;
      end
      DEAL_P3: w_next = BEVAL;
      BEVAL:   w_next = banker_draws(w_dscore, card_value(r_pcard3)) ? DEAL_D3 : DONE;
      DEAL_D3: w_next = DONE;
      DONE:    w_next = DONE;
      default: w_next = DEAL_P1;
    endcase
  end

  // Card registers: each deal state captures new_card into its own slot.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      r_pcard1 <= '0;
      r_pcard2 <= '0;
      r_pcard3 <= '0;
      r_dcard1 <= '0;
      r_dcard2 <= '0;
      r_dcard3 <= '0;
    end else begin
      case (r_state)
        DEAL_P1: r_pcard1 <= new_card;
        DEAL_D1: r_dcard1 <= new_card;
        DEAL_P2: r_pcard2 <= new_card;
        DEAL_D2: r_dcard2 <= new_card;
        DEAL_P3: r_pcard3 <= new_card;
        DEAL_D3: r_dcard3 <= new_card;
        default: ;
      endcase
    end
  end

  assign pcard1           = r_pcard1;
  assign pcard2           = r_pcard2;
  assign pcard3           = r_pcard3;
  assign dcard1           = r_dcard1;
  assign dcard2           = r_dcard2;
  assign dcard3           = r_dcard3;
  assign pscore           = w_pscore;
  assign dscore           = w_dscore;
  assign done             = (r_state == DONE);
  assign player_win_light = done && (w_pscore >= w_dscore);
  assign dealer_win_light = done && (w_dscore >= w_pscore);
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_baccarat_dealer.sv
// Bench for baccarat_dealer: directed table of hands, a mid-deal reset
// sequence and random hands checked edge by edge against a rules model.
module tb_baccarat_dealer;
  import baccarat_pkg::state_t;

  // ---------------- clock / reset ----------------
  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic [3:0] new_card   = 4'd0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       player_win_light, dealer_win_light, done;
  state_t     dbg_state;

  always #5 slow_clock = ~slow_clock;

  baccarat_dealer #(.CARD_W(4)) dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .new_card         (new_card),
    .pcard1           (pcard1),
    .pcard2           (pcard2),
    .pcard3           (pcard3),
    .dcard1           (dcard1),
    .dcard2           (dcard2),
    .dcard3           (dcard3),
    .pscore           (pscore),
    .dscore           (dscore),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .done             (done),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int val(input int code);
    return (code >= 1 && code <= 9) ? code : 0;
  endfunction

  function automatic bit bank_draw(input int ds, input int v);
    int lo[8] = '{0, 0, 0, 0, 2, 4, 6, 99};
    if (ds <= 2) return 1'b1;
    if (ds == 3) return (v != 8);
    return (v >= lo[ds]) && (v <= 7);
  endfunction

  // Register order: p1, p2, p3, d1, d2, d3. reg_edge 0 = never dealt.
  typedef struct {
    int reg_card[6];
    int reg_edge[6];
    int done_edge;
  } plan_t;

  function automatic plan_t make_plan(input int c[6]);
    plan_t p;
    int ps, ds;
    for (int j = 0; j < 6; j++) begin
      p.reg_card[j] = 0;
      p.reg_edge[j] = 0;
    end
    p.reg_card[0] = c[0]; p.reg_edge[0] = 1;
    p.reg_card[3] = c[1]; p.reg_edge[3] = 2;
    p.reg_card[1] = c[2]; p.reg_edge[1] = 3;
    p.reg_card[4] = c[3]; p.reg_edge[4] = 4;
    ps = (val(c[0]) + val(c[2])) % 10;
    ds = (val(c[1]) + val(c[3])) % 10;
    if (ps >= 8 || ds >= 8) begin
      p.done_edge = 5;
    end else if (ps <= 5) begin
      p.reg_card[2] = c[4]; p.reg_edge[2] = 6;
      if (bank_draw(ds, val(c[4]))) begin
        p.reg_card[5] = c[5]; p.reg_edge[5] = 8;
        p.done_edge = 8;
      end else begin
        p.done_edge = 7;
      end
    end else if (ds <= 5) begin
      p.reg_card[5] = c[4]; p.reg_edge[5] = 6;
      p.done_edge = 6;
    end else begin
      p.done_edge = 5;
    end
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string tag);
    logic [3:0] act[6];
    string rn[6] = '{"pcard1", "pcard2", "pcard3", "dcard1", "dcard2", "dcard3"};
    act = '{pcard1, pcard2, pcard3, dcard1, dcard2, dcard3};
    for (int j = 0; j < 6; j++) chk($sformatf("%s %s", tag, rn[j]), act[j], 0);
    chk($sformatf("%s done", tag), done, 0);
    chk($sformatf("%s pwin", tag), player_win_light, 0);
    chk($sformatf("%s dwin", tag), dealer_win_light, 0);
  endtask

  // Plays one hand (plus 5 idle edges in DONE) and checks every output each edge.
  task automatic run_hand(input string tag, input int c[6], input bit do_reset,
                          output int obs_done);
    plan_t p;
    int card_in, eps, eds, dn;
    int ex[6];
    logic [3:0] act[6];
    string rn[6] = '{"pcard1", "pcard2", "pcard3", "dcard1", "dcard2", "dcard3"};
    p = make_plan(c);
    obs_done = 0;
    if (do_reset) begin
      @(negedge slow_clock);
      resetb = 1'b0;
      @(posedge slow_clock); #1;
      check_idle($sformatf("%s rst", tag));
    end
    for (int e = 1; e <= p.done_edge + 5; e++) begin
      @(negedge slow_clock);
      resetb  = 1'b1;
      card_in = int'($urandom_range(0, 15));
      for (int j = 0; j < 6; j++) if (p.reg_edge[j] == e) card_in = p.reg_card[j];
      new_card = card_in[3:0];
      @(posedge slow_clock); #1;
      act = '{pcard1, pcard2, pcard3, dcard1, dcard2, dcard3};
      for (int j = 0; j < 6; j++) begin
        ex[j] = (p.reg_edge[j] != 0 && p.reg_edge[j] <= e) ? p.reg_card[j] : 0;
        chk($sformatf("%s e%0d %s", tag, e, rn[j]), act[j], ex[j]);
      end
      eps = (val(ex[0]) + val(ex[1]) + val(ex[2])) % 10;
      eds = (val(ex[3]) + val(ex[4]) + val(ex[5])) % 10;
      dn  = (e >= p.done_edge) ? 1 : 0;
      chk($sformatf("%s e%0d pscore", tag, e), pscore, eps);
      chk($sformatf("%s e%0d dscore", tag, e), dscore, eds);
      chk($sformatf("%s e%0d done", tag, e), done, dn);
      chk($sformatf("%s e%0d pwin", tag, e), player_win_light, (dn != 0 && eps >= eds) ? 1 : 0);
      chk($sformatf("%s e%0d dwin", tag, e), dealer_win_light, (dn != 0 && eds >= eps) ? 1 : 0);
      if (done === 1'b1 && obs_done == 0) obs_done = e;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int c[6];
    int ps, ds, pw, dw, de, p3, d3;
  } vec_t;

  vec_t tbl[6];

  task automatic check_final(input int i, input int od);
    string t;
    t = $sformatf("vec%0d", i);
    chk({t, " done_edge"}, od, tbl[i].de);
    chk({t, " pscore"}, pscore, tbl[i].ps);
    chk({t, " dscore"}, dscore, tbl[i].ds);
    chk({t, " pwin"}, player_win_light, tbl[i].pw);
    chk({t, " dwin"}, dealer_win_light, tbl[i].dw);
    chk({t, " pcard3"}, pcard3, tbl[i].p3);
    chk({t, " dcard3"}, dcard3, tbl[i].d3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int od;
    int rc[6];
    plan_t rp;

    tbl[0] = '{'{4, 2, 5, 3, 0, 0},     9, 5, 1, 0, 5, 0, 0};
    tbl[1] = '{'{10, 7, 7, 13, 0, 0},   7, 7, 1, 1, 5, 0, 0};
    tbl[2] = '{'{2, 3, 1, 3, 7, 2},     0, 8, 0, 1, 8, 7, 2};
    tbl[3] = '{'{1, 1, 1, 2, 8, 0},     0, 3, 0, 1, 7, 8, 0};
    tbl[4] = '{'{12, 4, 6, 10, 5, 0},   6, 9, 0, 1, 6, 0, 5};
    tbl[5] = '{'{0, 0, 0, 0, 11, 6},    0, 6, 0, 1, 8, 11, 6};

    resetb   = 1'b0;
    new_card = 4'd0;
    repeat (2) @(posedge slow_clock);
    #1;
    check_idle("por");

    for (int i = 0; i < 5; i++) begin
      run_hand($sformatf("vec%0d", i), tbl[i].c, 1'b1, od);
      check_final(i, od);
    end

    // Reset in the middle of a deal, then deal a fresh hand without another reset.
    @(negedge slow_clock); resetb = 1'b0;
    @(posedge slow_clock);
    @(negedge slow_clock); resetb = 1'b1; new_card = 4'd9;
    @(posedge slow_clock);
    @(negedge slow_clock); new_card = 4'd9;
    @(posedge slow_clock); #1;
    chk("mid pcard1", pcard1, 9);
    chk("mid dcard1", dcard1, 9);
    @(negedge slow_clock); resetb = 1'b0; new_card = 4'd9;
    @(posedge slow_clock); #1;
    check_idle("mid");
    chk("mid pscore", pscore, 0);
    chk("mid dscore", dscore, 0);
    run_hand("vec5", tbl[5].c, 1'b0, od);
    check_final(5, od);

    // Random hands against the rules model.
    for (int h = 0; h < 60; h++) begin
      for (int k = 0; k < 6; k++) rc[k] = int'($urandom_range(0, 15));
      rp = make_plan(rc);
      run_hand($sformatf("rnd%0d", h), rc, 1'b1, od);
      chk($sformatf("rnd%0d done_edge", h), od, rp.done_edge);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
